// File: rtl/ha_sched_pkg.sv
// Shared types and sizes for the HA scheduler.
// The watchdog feature is enabled by HA_SCHED_TIMEOUT_EN.
package ha_sched_pkg;

   localparam int N_W         = 4;
   localparam int SUM_W       = 19;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_LO,
      WAIT_HI,
      DONE
   } state_e;

endpackage

// File: rtl/ha_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with an internal last-served pointer.
// The pointer moves only when the advance strobe accepts a grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (adv_i && (gnt_o != 2'b00))
         last_d = gnt_o[1];
   end

   // last_q=1 after reset so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset)
         last_q <= 1'b1;
      else
         last_q <= last_d;
   end

endmodule

// File: rtl/ha_scheduler.sv
// Shares one engine between two requesters, round-robin.
// HA_SCHED_TIMEOUT_EN adds a watchdog on the engine wait states.
module ha_scheduler
   import ha_sched_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [N_W-1:0]   n0,
   input  logic [N_W-1:0]   n1,
   output logic [1:0]       gnt,
   output logic [1:0]       rsp_valid,
   output logic [SUM_W-1:0] rsp_sum,
   output logic             rsp_err,
   output logic             eng_start,
   output logic [N_W-1:0]   eng_n,
   input  logic             eng_ready,
   input  logic [SUM_W-1:0] eng_sum
);

   state_e           state_q;
   state_e           state_d;
   logic [1:0]       gnt_q;
   logic [1:0]       gnt_d;
   logic [N_W-1:0]   eng_n_q;
   logic [N_W-1:0]   eng_n_d;
   logic [SUM_W-1:0] sum_q;
   logic [SUM_W-1:0] sum_d;
   logic             adv;
   logic [1:0]       arb_gnt;
   logic [N_W-1:0]   n_sel;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (req),
      .adv_i (adv),
      .gnt_o (arb_gnt)
   );

   assign n_sel = arb_gnt[1] ? n1 : n0;

`ifdef HA_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;
   logic             err_d;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      eng_n_d = eng_n_q;
      sum_d   = sum_q;
      adv     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((req != 2'b00) && eng_ready) begin
               adv     = 1'b1;
               gnt_d   = arb_gnt;
               eng_n_d = n_sel;
               sum_d   = '0;
               // A zero-term job never touches the engine.
               state_d = (n_sel == '0) ? DONE : START;
            end
         end
         START:   state_d = WAIT_LO;
         WAIT_LO: begin
            if (!eng_ready)
               state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (eng_ready) begin
               sum_d   = eng_sum;
               state_d = DONE;
            end
         end
         DONE: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef HA_SCHED_TIMEOUT_EN
      cnt_d = cnt_q;
      err_d = err_q;
      if (adv)
         err_d = 1'b0;
      if (state_q == IDLE)
         cnt_d = '0;
      // Watchdog wins over a same-cycle engine completion.
      if ((state_q == WAIT_LO) || (state_q == WAIT_HI)) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            sum_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         eng_n_q <= '0;
         sum_q   <= '0;
`ifdef HA_SCHED_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         eng_n_q <= eng_n_d;
         sum_q   <= sum_d;
`ifdef HA_SCHED_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      eng_start = 1'b0;
      rsp_valid = 2'b00;
      unique case (state_q)
         START:   eng_start = 1'b1;
         DONE:    rsp_valid = gnt_q;
         default: ;
      endcase
   end

   assign gnt     = gnt_q;
   assign eng_n   = eng_n_q;
   assign rsp_sum = sum_q;

`ifdef HA_SCHED_TIMEOUT_EN
   assign rsp_err = err_q;
`else
   // TIMEOUT only matters when the watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign rsp_err        = 1'b0;
`endif

endmodule

// File: doc/ha_scheduler.md
HA_SCHEDULER -- requirements
Module: ha_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the engine watchdog limit in cycles (used only with HA_SCHED_TIMEOUT_EN).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req  input  2  per-requester level request; held until the matching rsp_valid.
REQ-006 n0, n1  input  4 each  term count for requester 0 and requester 1.
REQ-007 gnt  output  2  one-hot grant, high for the whole service of the granted requester.
REQ-008 rsp_valid  output  2  one-cycle completion pulse to the granted requester.
REQ-009 rsp_sum  output  19  result; valid only while rsp_valid is non-zero.
REQ-010 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-011 eng_start, eng_n  output  1, 4  engine start pulse and term count.
REQ-012 eng_ready, eng_sum  input  1, 19  engine idle flag and engine accumulated sum.

Function
REQ-013 States SHALL be IDLE, START, WAIT_LO, WAIT_HI, DONE.
REQ-014 IDLE: when req is non-zero and eng_ready=1, the block SHALL select one requester round-robin, set gnt, latch that requester's n into eng_n, and go to START on the next edge.
REQ-015 Round-robin: the requester not served last SHALL win when both request; the pointer SHALL update at each grant.
REQ-016 START SHALL last exactly one cycle with eng_start=1; eng_start SHALL be 0 in every other state.
REQ-017 From START the block SHALL go to WAIT_LO.
REQ-018 WAIT_LO SHALL hold until eng_ready=0, then go to WAIT_HI.
REQ-019 WAIT_HI SHALL hold until eng_ready=1, then capture eng_sum into rsp_sum and go to DONE.
REQ-020 DONE SHALL pulse rsp_valid[granted] for one cycle, clear gnt on the following edge, and return to IDLE.
REQ-021 If the latched n is 0, START SHALL be skipped: IDLE goes straight to DONE with rsp_sum=0 and no eng_start.
REQ-022 A req bit that drops before it is granted SHALL be ignored; no response is issued for it.
REQ-023 A req that stays high after its rsp_valid SHALL be treated as a new request at lower priority than the other requester.
REQ-024 Minimum latency SHALL be 4 cycles from grant to rsp_valid, plus the engine's busy time.
REQ-025 eng_n SHALL stay stable from START until DONE.

Reset
REQ-026 On reset the block SHALL enter IDLE, with gnt=0, rsp_valid=0, rsp_sum=0, rsp_err=0, eng_start=0, eng_n=0.
REQ-027 After reset the round-robin pointer SHALL favour requester 0 first.
REQ-028 Reset during any state SHALL abort the service silently, with no rsp_valid; the engine is reset independently.

Configuration
REQ-029 Macro HA_SCHED_TIMEOUT_EN defined: a watchdog counter runs in WAIT_LO and WAIT_HI.
- When the counter reaches TIMEOUT, the block SHALL go to DONE with rsp_sum=0 and rsp_err=1.
REQ-030 Macro HA_SCHED_TIMEOUT_EN undefined: there SHALL be no counter, rsp_err SHALL be tied 0, and the wait states SHALL wait indefinitely.

Structure
REQ-031 Package ha_sched_pkg SHALL hold the state enum, N_W=4, SUM_W=19 and the default TIMEOUT.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter2.
- Inputs: req and an advance strobe.
- Output: one-hot grant.
- Holds the last-served pointer internally.

Verification
Bench engine model: after eng_start, eng_ready drops for n+2 cycles, then returns with eng_sum = 19'h00100*n.
REQ-033 Single request: req=01, n0=5 -> gnt=01, one eng_start with eng_n=5, then rsp_valid=01 with rsp_sum=19'h00500.
REQ-034 Contention: req=11 held, n0=3, n1=7 -> requester 0 served first (19'h00300), then requester 1 (19'h00700), then requester 0 again.
REQ-035 n=0: req=10, n1=0 -> no eng_start, and rsp_valid=10 with rsp_sum=0 within 2 cycles.
REQ-036 Reset mid-run: assert reset while in WAIT_HI -> next cycle gnt=0, and no rsp_valid ever follows for that request.
REQ-037 With HA_SCHED_TIMEOUT_EN, TIMEOUT=16, engine stuck with eng_ready=0 -> rsp_valid pulses at cycle 16 of waiting with rsp_err=1 and rsp_sum=0.
REQ-038 Withdrawn request: req=01 drops while eng_ready=0 before any grant -> no gnt and no response.
